// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: registers decoded operands and control,
// derives the ALU control code, forwards from EX/MEM and MEM/WB, and inserts load-use bubbles.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [2:0]        id_funct3,
   input  logic              id_funct7_5,
   input  logic [1:0]        id_alu_op,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              exmem_reg_write,
   input  logic [RA_W-1:0]   exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [RA_W-1:0]   memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_src1,
   output logic [DATA_W-1:0] ex_src2,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [3:0]        ex_alu_control,
   output logic [RA_W-1:0]   ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              load_use_stall
);

   logic [DATA_W-1:0] rs1_data_q, rs2_data_q, imm_q;
   logic [RA_W-1:0]   rs1_q, rs2_q, rd_q;
   logic [3:0]        alu_ctrl_q;
   logic              valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

   function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [2:0] f3,
                                             input logic f7);
      logic [3:0] code;
      code = 4'b0010;
      if (op == 2'b01) begin
         code = 4'b0110;
      end else if (op[1]) begin
         case (f3)
            3'b000:  code = (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
            3'b001:  code = 4'b1100;
            3'b010:  code = 4'b0111;
            3'b100:  code = 4'b0011;
            3'b101:  code = f7 ? 4'b1001 : 4'b1000;
            3'b110:  code = 4'b0001;
            3'b111:  code = 4'b0000;
            default: code = 4'b0010;
         endcase
      end
      return code;
   endfunction

   // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (exmem_reg_write && exmem_rd == rs1_q && rs1_q != '0)
         fwd_rs1 = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs1_q && rs1_q != '0)
         fwd_rs1 = memwb_result;
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (exmem_reg_write && exmem_rd == rs2_q && rs2_q != '0)
         fwd_rs2 = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs2_q && rs2_q != '0)
         fwd_rs2 = memwb_result;
   end

   assign load_use_stall = valid_q && mem_read_q && (rd_q != '0) &&
                           ((rd_q == id_rs1) || (rd_q == id_rs2));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         alu_ctrl_q   <= 4'b0010;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else if (flush || (!hold && load_use_stall)) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else if (hold) begin
         // Capture forwarded operands so a producer retiring during the hold is kept.
         rs1_data_q <= fwd_rs1;
         rs2_data_q <= fwd_rs2;
      end else begin
         valid_q      <= id_valid;
         rs1_data_q   <= id_rs1_data;
         rs2_data_q   <= id_rs2_data;
         imm_q        <= id_imm;
         rs1_q        <= id_rs1;
         rs2_q        <= id_rs2;
         rd_q         <= id_rd;
         alu_ctrl_q   <= alu_decode(id_alu_op, id_funct3, id_funct7_5);
         alu_src_q    <= id_alu_src;
         reg_write_q  <= id_reg_write;
         mem_read_q   <= id_mem_read;
         mem_write_q  <= id_mem_write;
         mem_to_reg_q <= id_mem_to_reg;
      end
   end

   assign ex_valid       = valid_q;
   assign ex_src1        = fwd_rs1;
   assign ex_src2        = alu_src_q ? imm_q : fwd_rs2;
   assign ex_store_data  = fwd_rs2;
   assign ex_alu_control = alu_ctrl_q;
   assign ex_rd          = rd_q;
   assign ex_reg_write   = reg_write_q;
   assign ex_mem_read    = mem_read_q;
   assign ex_mem_write   = mem_write_q;
   assign ex_mem_to_reg  = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table-driven ALU decode vectors plus hand-written
// sequences for forwarding, load-use stall, hold refresh, flush and reset priority.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, hold, flush, id_valid;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3;
   logic        id_funct7_5;
   logic [1:0]  id_alu_op;
   logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        ex_valid;
   logic [31:0] ex_src1, ex_src2, ex_store_data;
   logic [3:0]  ex_alu_control;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_alu_op(id_alu_op),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_src1(ex_src1), .ex_src2(ex_src2),
      .ex_store_data(ex_store_data), .ex_alu_control(ex_alu_control), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
   );

   typedef struct {
      logic [1:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [3:0] exp_ctrl;
   } dec_vec_t;

   dec_vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hold = 0; flush = 0; id_valid = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_funct3 = 0; id_funct7_5 = 0; id_alu_op = 0; id_alu_src = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic set_id(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic asrc);
      id_valid = 1; id_alu_op = op; id_funct3 = f3; id_funct7_5 = f7;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = asrc;
      id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
   endtask

   initial begin
      vecs[0]  = '{2'b10, 3'b000, 1'b1, 4'b0110};
      vecs[1]  = '{2'b11, 3'b101, 1'b1, 4'b1001};
      vecs[2]  = '{2'b00, 3'b111, 1'b1, 4'b0010};
      vecs[3]  = '{2'b01, 3'b001, 1'b0, 4'b0110};
      vecs[4]  = '{2'b10, 3'b000, 1'b0, 4'b0010};
      vecs[5]  = '{2'b11, 3'b000, 1'b1, 4'b0010};
      vecs[6]  = '{2'b10, 3'b001, 1'b0, 4'b1100};
      vecs[7]  = '{2'b10, 3'b010, 1'b0, 4'b0111};
      vecs[8]  = '{2'b10, 3'b100, 1'b0, 4'b0011};
      vecs[9]  = '{2'b10, 3'b101, 1'b0, 4'b1000};
      vecs[10] = '{2'b10, 3'b110, 1'b0, 4'b0001};
      vecs[11] = '{2'b11, 3'b111, 1'b0, 4'b0000};
      vecs[12] = '{2'b10, 3'b011, 1'b1, 4'b0010};

      // Reset with a live instruction at ID: it must not leak through.
      idle_inputs();
      set_id(2'b10, 3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0);
      rst_n = 0;
      tick(); tick();
      chk("rst_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_ctrl", {28'b0, ex_alu_control}, 32'h2);
      chk("rst_regwrite", {31'b0, ex_reg_write}, 32'd0);
      chk("rst_stall", {31'b0, load_use_stall}, 32'd0);
      chk("rst_rd", {27'b0, ex_rd}, 32'd0);
      rst_n = 1;

      // Decode table; first entry is rs1=5/rs2=6 with data 9/4.
      for (int i = 0; i < 13; i++) begin
         logic [31:0] d1, d2, imm;
         logic        asrc;
         d1   = (i == 0) ? 32'd9 : 32'h100 + i;
         d2   = (i == 0) ? 32'd4 : 32'h200 + i;
         imm  = 32'h300 + i;
         asrc = (i % 2 == 1);
         set_id(vecs[i].op, vecs[i].f3, vecs[i].f7, 5'd5, 5'd6, 5'd10, d1, d2, imm, asrc);
         tick();
         chk($sformatf("dec%0d_ctrl", i), {28'b0, ex_alu_control}, {28'b0, vecs[i].exp_ctrl});
         chk($sformatf("dec%0d_src1", i), ex_src1, d1);
         chk($sformatf("dec%0d_src2", i), ex_src2, asrc ? imm : d2);
         chk($sformatf("dec%0d_store", i), ex_store_data, d2);
         chk($sformatf("dec%0d_valid", i), {31'b0, ex_valid}, 32'd1);
      end

      // Forwarding priority on registered rs1=3, rs2=4.
      set_id(2'b00, 3'b000, 1'b0, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h0, 1'b0);
      tick();
      idle_inputs();
      hold = 1;
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
      #1;
      chk("fwd_exmem_wins", ex_src1, 32'hAA);
      chk("fwd_rs2_untouched", ex_src2, 32'h22);
      exmem_reg_write = 0;
      #1;
      chk("fwd_memwb", ex_src1, 32'hBB);
      exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
      #1;
      chk("fwd_rd0_none", ex_src1, 32'h11);
      exmem_rd = 4; exmem_result = 32'hCC;
      #1;
      chk("fwd_rs2_src2", ex_src2, 32'hCC);
      chk("fwd_rs2_store", ex_store_data, 32'hCC);
      idle_inputs();

      // x0 is never forwarded even when a producer claims rd=0.
      set_id(2'b00, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9, 32'h33, 32'h44, 32'h0, 1'b0);
      tick();
      idle_inputs();
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
      #1;
      chk("fwd_x0_src1", ex_src1, 32'h33);
      chk("fwd_x0_store", ex_store_data, 32'h44);
      idle_inputs();

      // Load-use: lw x7 in EX, add uses rs2=x7.
      set_id(2'b00, 3'b000, 1'b0, 5'd2, 5'd0, 5'd7, 32'h1000, 32'h0, 32'h4, 1'b1);
      id_mem_read = 1; id_mem_to_reg = 1;
      tick();
      set_id(2'b10, 3'b000, 1'b0, 5'd1, 5'd7, 5'd8, 32'h5, 32'h0, 32'h0, 1'b0);
      #1;
      chk("lu_stall", {31'b0, load_use_stall}, 32'd1);
      tick();
      chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
      chk("lu_bubble_memread", {31'b0, ex_mem_read}, 32'd0);
      chk("lu_bubble_regwrite", {31'b0, ex_reg_write}, 32'd0);
      chk("lu_stall_cleared", {31'b0, load_use_stall}, 32'd0);
      tick();
      memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h77;
      #1;
      chk("lu_add_valid", {31'b0, ex_valid}, 32'd1);
      chk("lu_add_src2", ex_src2, 32'h77);
      chk("lu_add_src1", ex_src1, 32'h5);
      idle_inputs();

      // Load to x0 never stalls.
      set_id(2'b00, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
      id_mem_read = 1;
      tick();
      set_id(2'b10, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("lu_rd0_nostall", {31'b0, load_use_stall}, 32'd0);

      // Stall raised under hold: hold keeps the load, stall still asserted.
      set_id(2'b00, 3'b000, 1'b0, 5'd2, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 1'b1);
      id_mem_read = 1;
      tick();
      set_id(2'b10, 3'b000, 1'b0, 5'd12, 5'd3, 5'd8, 32'h0, 32'h0, 32'h0, 1'b0);
      hold = 1;
      #1;
      chk("hold_stall_req", {31'b0, load_use_stall}, 32'd1);
      tick();
      chk("hold_over_stall_valid", {31'b0, ex_valid}, 32'd1);
      chk("hold_over_stall_memread", {31'b0, ex_mem_read}, 32'd1);
      idle_inputs();

      // Hold refresh: rs1=8, MEM/WB supplies 0x55 in hold cycle 1 only.
      set_id(2'b10, 3'b110, 1'b0, 5'd8, 5'd9, 5'd11, 32'h10, 32'h20, 32'h0, 1'b0);
      tick();
      hold = 1;
      set_id(2'b10, 3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 32'hF1, 32'hF2, 32'h0, 1'b0);
      memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h55;
      #1;
      chk("hold_c1_src1", ex_src1, 32'h55);
      tick();
      memwb_reg_write = 0; memwb_result = 32'h0;
      #1;
      chk("hold_c2_src1", ex_src1, 32'h55);
      chk("hold_c2_ctrl", {28'b0, ex_alu_control}, 32'h1);
      tick();
      chk("hold_c3_src1", ex_src1, 32'h55);
      chk("hold_c3_src2", ex_src2, 32'h20);
      chk("hold_c3_rd", {27'b0, ex_rd}, 32'd11);
      idle_inputs();

      // flush and hold together with a store in EX.
      set_id(2'b00, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h8, 1'b1);
      id_mem_write = 1; id_reg_write = 0;
      tick();
      chk("store_in_ex", {31'b0, ex_mem_write}, 32'd1);
      flush = 1; hold = 1;
      tick();
      chk("flush_hold_valid", {31'b0, ex_valid}, 32'd0);
      chk("flush_hold_memwrite", {31'b0, ex_mem_write}, 32'd0);
      idle_inputs();

      // Reset during a hold wins.
      set_id(2'b10, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      hold = 1; rst_n = 0;
      tick();
      chk("rst_hold_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_hold_ctrl", {28'b0, ex_alu_control}, 32'h2);
      rst_n = 1; idle_inputs();
      tick();
      chk("post_rst_valid", {31'b0, ex_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
